// File: rtl/head_mem_pkg.sv
// head_mem_pkg: shared types and default widths for the head memory access master.
package head_mem_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
  localparam int DEF_ADDR_W = 19;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LEN_W = 8;
  localparam int DEF_RSP_DEPTH = 4;
  typedef struct packed {
    logic last;
    logic [DEF_DATA_W-1:0] data;
  } rsp_beat_t;
endpackage

// File: rtl/head_mem_rsp_fifo.sv
// head_mem_rsp_fifo: register-array FIFO with occupancy count and simultaneous push/pop.
module head_mem_rsp_fifo #(
  parameter int W = 17,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  logic [W-1:0] i_data,
  input  logic i_pop,
  output logic o_vld,
  output logic [W-1:0] o_data,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_pop, w_push;
  assign w_pop = i_pop && r_cnt != '0;
  assign w_push = i_push && (r_cnt != (AW+1)'(DEPTH) || w_pop);
  assign o_vld = r_cnt != '0;
  assign o_data = r_mem[r_rp];
  assign o_count = r_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_data;
        r_wp <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/head_mem_master.sv
// head_mem_master: turns burst commands into single-beat head memory strobes and
// returns read data through a credit-limited response FIFO.
module head_mem_master
  import head_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int RSP_DEPTH = DEF_RSP_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_vld,
  output logic cmd_rdy,
  input  logic cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic wr_vld,
  output logic wr_rdy,
  input  logic [DATA_W-1:0] wr_data,
  output logic rsp_vld,
  input  logic rsp_rdy,
  output logic [DATA_W-1:0] rsp_data,
  output logic rsp_last,
  output logic [ADDR_W-1:0] head_mem_addr,
  output logic [DATA_W-1:0] head_mem_wdata,
  output logic head_mem_wen,
  output logic head_mem_ren,
  input  logic [DATA_W-1:0] head_mem_rdata,
  input  logic head_mem_rvld,
  output logic busy,
  output logic err_unexpected_rvld
);
  localparam int CW = $clog2(RSP_DEPTH) + 1;
  state_t r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_issue_addr, r_hm_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [LEN_W-1:0] r_cnt, r_len, r_ret;
  logic [CW-1:0] r_out, w_fcnt, w_credit;
  logic r_wen, r_ren, r_err;
  logic w_accept, w_rd, w_wr, w_ret;
  logic [DATA_W:0] w_rsp_beat;
  // Outstanding reads plus buffered beats never exceed the FIFO depth, so this cannot underflow.
  assign w_credit = CW'(RSP_DEPTH) - r_out - w_fcnt;
  assign w_ret = head_mem_rvld && r_out != '0;
  always_comb begin
    w_state_nxt = r_state;
    cmd_rdy = 1'b0;
    wr_rdy = 1'b0;
    w_accept = 1'b0;
    w_rd = 1'b0;
    w_wr = 1'b0;
    w_issue_addr = r_addr;
    case (r_state)
      IDLE: begin
        cmd_rdy = rst_n;
        w_accept = cmd_vld && rst_n;
        w_issue_addr = cmd_addr;
        w_rd = w_accept && !cmd_write && w_credit != '0;
        if (w_accept) w_state_nxt = cmd_write ? WRITE : (w_rd && cmd_len == '0) ? DRAIN : READ;
      end
      WRITE: begin
        wr_rdy = 1'b1;
        w_wr = wr_vld;
        if (wr_vld && r_cnt == '0) w_state_nxt = IDLE;
      end
      READ: begin
        w_rd = w_credit != '0;
        if (w_rd && r_cnt == '0) w_state_nxt = DRAIN;
      end
      DRAIN: w_state_nxt = r_out == '0 ? IDLE : DRAIN;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_hm_addr <= '0;
      r_wdata <= '0;
      r_cnt <= '0;
      r_len <= '0;
      r_ret <= '0;
      r_out <= '0;
      r_wen <= 1'b0;
      r_ren <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_wen <= w_wr;
      r_ren <= w_rd;
      if (w_wr || w_rd) begin
        r_hm_addr <= w_issue_addr;
        r_addr <= w_issue_addr + ADDR_W'(1);
      end else if (w_accept) begin
        r_addr <= cmd_addr;
      end
      if (w_wr) r_wdata <= wr_data;
      // A read issued in the accept cycle already consumes the first beat.
      if (w_accept) begin
        r_len <= cmd_len;
        r_ret <= '0;
        r_cnt <= w_rd ? cmd_len - LEN_W'(1) : cmd_len;
      end else begin
        if (w_wr || w_rd) r_cnt <= r_cnt - LEN_W'(1);
        if (w_ret) r_ret <= r_ret + LEN_W'(1);
      end
      r_out <= r_out + CW'(w_rd) - CW'(w_ret);
      if (head_mem_rvld && r_out == '0) r_err <= 1'b1;
    end
  end
  head_mem_rsp_fifo #(.W(DATA_W + 1), .DEPTH(RSP_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .i_push(w_ret),
    .i_data({r_ret == r_len, head_mem_rdata}),
    .i_pop(rsp_rdy),
    .o_vld(rsp_vld),
    .o_data(w_rsp_beat),
    .o_count(w_fcnt)
  );
  assign rsp_data = w_rsp_beat[DATA_W-1:0];
  assign rsp_last = w_rsp_beat[DATA_W];
  assign head_mem_addr = r_hm_addr;
  assign head_mem_wdata = r_wdata;
  assign head_mem_wen = r_wen;
  assign head_mem_ren = r_ren;
  assign busy = r_state != IDLE || r_out != '0 || w_fcnt != '0;
  assign err_unexpected_rvld = r_err;
endmodule

// File: tb/tb_head_mem_master.sv
// tb_head_mem_master: directed checks of head_mem_master against a two-cycle head_top read model.
module tb_head_mem_master;
  logic clk, rst_n;
  logic cmd_vld, cmd_rdy, cmd_write;
  logic [18:0] cmd_addr;
  logic [7:0] cmd_len;
  logic wr_vld, wr_rdy;
  logic [15:0] wr_data;
  logic rsp_vld, rsp_rdy, rsp_last;
  logic [15:0] rsp_data;
  logic [18:0] head_mem_addr;
  logic [15:0] head_mem_wdata, head_mem_rdata;
  logic head_mem_wen, head_mem_ren, head_mem_rvld;
  logic busy, err_unexpected_rvld;
  logic man_rvld;
  logic p1_v, p2_v;
  logic [18:0] p1_a, p2_a;
  int ren_cnt, occ, max_occ;
  logic [16:0] rsp_q[$];
  int checks, errors;

  head_mem_master dut (
    .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_data(wr_data),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .head_mem_addr(head_mem_addr), .head_mem_wdata(head_mem_wdata), .head_mem_wen(head_mem_wen),
    .head_mem_ren(head_mem_ren), .head_mem_rdata(head_mem_rdata), .head_mem_rvld(head_mem_rvld),
    .busy(busy), .err_unexpected_rvld(err_unexpected_rvld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // head_top stand-in: read data returns two cycles after each strobe
  always @(posedge clk) begin
    p1_v <= head_mem_ren;
    p1_a <= head_mem_addr;
    p2_v <= p1_v;
    p2_a <= p1_a;
  end
  assign head_mem_rvld = p2_v | man_rvld;
  assign head_mem_rdata = man_rvld ? 16'hDEAD : (p2_a[15:0] ^ 16'h5A5A);

  initial begin
    ren_cnt = 0;
    occ = 0;
    max_occ = 0;
  end
  always @(negedge clk) begin
    if (head_mem_ren) ren_cnt <= ren_cnt + 1;
    if (rsp_vld && rsp_rdy) rsp_q.push_back({rsp_last, rsp_data});
    occ <= occ + int'(head_mem_ren) - int'(rsp_vld && rsp_rdy);
    max_occ <= occ > max_occ ? occ : max_occ;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic wr, input logic [18:0] a, input logic [7:0] l);
    cmd_vld = 1'b1;
    cmd_write = wr;
    cmd_addr = a;
    cmd_len = l;
    step();
    cmd_vld = 1'b0;
  endtask

  initial begin
    int b, rb, k;
    logic [16:0] e;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    cmd_vld = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    wr_vld = 1'b0;
    wr_data = '0;
    rsp_rdy = 1'b0;
    man_rvld = 1'b0;
    step();
    step();
    chk("rst_cmd_rdy", cmd_rdy, 0);
    chk("rst_wr_rdy", wr_rdy, 0);
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_hm_addr", head_mem_addr, 0);
    chk("rst_strobes", {head_mem_wen, head_mem_ren}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_unexpected_rvld, 0);
    rst_n = 1'b1;
    step();
    chk("idle_cmd_rdy", cmd_rdy, 1);

    // write burst with a stall before the third beat
    rb = ren_cnt;
    send_cmd(1'b1, 19'h00001, 8'd3);
    chk("wr_state_rdy", wr_rdy, 1);
    chk("wr_cmd_rdy_low", cmd_rdy, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        wr_vld = 1'b0;
        step();
        chk("wr_stall_wen", head_mem_wen, 0);
      end
      wr_vld = 1'b1;
      wr_data = 16'hABCD + 16'(i);
      step();
      chk("wr_wen", head_mem_wen, 1);
      chk("wr_addr", head_mem_addr, 32'h1 + i);
      chk("wr_data", head_mem_wdata, 32'hABCD + i);
    end
    wr_vld = 1'b0;
    chk("wr_done_idle", cmd_rdy, 1);
    step();
    chk("wr_wen_off", head_mem_wen, 0);
    chk("wr_no_ren", ren_cnt - rb, 0);

    // read burst, responder returns two cycles after each strobe
    rsp_rdy = 1'b1;
    b = rsp_q.size();
    send_cmd(1'b0, 19'h00010, 8'd7);
    chk("rd_first_ren", head_mem_ren, 1);
    chk("rd_first_addr", head_mem_addr, 32'h10);
    chk("rd_no_wen", head_mem_wen, 0);
    for (int c = 0; c < 100 && rsp_q.size() - b < 8; c++) step();
    chk("rd_count", rsp_q.size() - b, 8);
    chk("rd_busy_after", busy, 0);
    for (int i = 0; i < 8 && b + i < rsp_q.size(); i++) begin
      e = rsp_q[b + i];
      chk("rd_data", e[15:0], (32'h10 + i) ^ 32'h5A5A);
      chk("rd_last", e[16], i == 7);
    end

    // backpressure: only the FIFO depth may be in flight plus buffered
    rsp_rdy = 1'b0;
    rb = ren_cnt;
    b = rsp_q.size();
    send_cmd(1'b0, 19'h00100, 8'd15);
    repeat (20) step();
    chk("bp_ren_stall", ren_cnt - rb, 4);
    chk("bp_ren_now", head_mem_ren, 0);
    chk("bp_rsp_vld", rsp_vld, 1);
    chk("bp_hold_data", rsp_data, 16'h0100 ^ 16'h5A5A);
    step();
    chk("bp_hold_data2", rsp_data, 16'h0100 ^ 16'h5A5A);
    chk("bp_hold_last", rsp_last, 0);
    rsp_rdy = 1'b1;
    for (int c = 0; c < 300 && rsp_q.size() - b < 16; c++) step();
    chk("bp_count", rsp_q.size() - b, 16);
    chk("bp_ren_total", ren_cnt - rb, 16);
    chk("bp_max_occ", max_occ <= 4, 1);
    chk("bp_max_occ_reached", max_occ, 4);
    for (int i = 0; i < 16 && b + i < rsp_q.size(); i++) begin
      e = rsp_q[b + i];
      chk("bp_data", e[15:0], (32'h100 + i) ^ 32'h5A5A);
      chk("bp_last", e[16], i == 15);
    end
    step();

    // address wrap
    send_cmd(1'b1, 19'h7FFFE, 8'd3);
    for (int i = 0; i < 4; i++) begin
      wr_vld = 1'b1;
      wr_data = 16'h1000 + 16'(i);
      step();
      chk("wrap_wen", head_mem_wen, 1);
      chk("wrap_addr", head_mem_addr, (32'h7FFFE + i) & 32'h7FFFF);
      chk("wrap_data", head_mem_wdata, 32'h1000 + i);
    end
    wr_vld = 1'b0;
    step();

    // unexpected read data while idle
    man_rvld = 1'b1;
    step();
    man_rvld = 1'b0;
    chk("err_set", err_unexpected_rvld, 1);
    step();
    step();
    chk("err_sticky", err_unexpected_rvld, 1);
    chk("err_no_rsp", rsp_vld, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("err_cleared", err_unexpected_rvld, 0);
    step();
    chk("err_stays_clear", err_unexpected_rvld, 0);

    // reset in the middle of a read burst
    k = 0;
    send_cmd(1'b0, 19'h00200, 8'd7);
    if (head_mem_ren) k++;
    for (int c = 0; c < 20 && k < 3; c++) begin
      step();
      if (head_mem_ren) k++;
    end
    chk("mid_three_reads", k, 3);
    rst_n = 1'b0;
    step();
    chk("mid_ren_off", head_mem_ren, 0);
    chk("mid_rsp_off", rsp_vld, 0);
    chk("mid_cmd_rdy_rst", cmd_rdy, 0);
    rst_n = 1'b1;
    step();
    chk("mid_cmd_rdy", cmd_rdy, 1);
    repeat (5) step();
    chk("mid_late_err", err_unexpected_rvld, 1);
    chk("mid_busy", busy, 0);
    b = rsp_q.size();
    send_cmd(1'b0, 19'h00300, 8'd0);
    chk("fresh_ren", head_mem_ren, 1);
    chk("fresh_addr", head_mem_addr, 32'h300);
    for (int c = 0; c < 20 && rsp_q.size() - b < 1; c++) step();
    chk("fresh_count", rsp_q.size() - b, 1);
    if (rsp_q.size() > b) begin
      e = rsp_q[b];
      chk("fresh_data", e[15:0], 16'h0300 ^ 16'h5A5A);
      chk("fresh_last", e[16], 1);
    end
    chk("fresh_busy", busy, 0);
    chk("fresh_cmd_rdy", cmd_rdy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
